// File: rtl/csr_timer_pkg.sv
// Shared constants for the LoongArch constant-timer CSRs: CSR addresses,
// TCFG/TICLR field positions and the ESTAT.IS bit that carries the timer interrupt.
package csr_timer_pkg;

    localparam int CSR_DATA_W = 32;

    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    localparam int TCFG_EN       = 0;
    localparam int TCFG_PERIODIC = 1;
    localparam int TCFG_INITVAL  = 2;
    localparam int TICLR_CLR     = 0;

    localparam int ESTAT_IS_TI   = 11;

endpackage

// File: rtl/csr_timer_stable_counter.sv
// 64-bit free-running stable counter with synchronous reset; the low-to-high
// carry happens inside a single 64-bit add, so both halves update on the same edge.
module csr_timer_stable_counter (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    assign cnt_d = cnt_q + 64'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign lo_o = cnt_q[31:0];
    assign hi_o = cnt_q[63:32];

endmodule

// File: rtl/csr_timer.sv
// Constant timer (TID/TCFG/TVAL/TICLR) and stable-counter source for the CSR unit.
// Define CSR_TIMER_STABLE_COUNTER_EN to build the 64-bit stable counter; otherwise cnt_lo/cnt_hi read 0.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int          TIMER_WIDTH = 32,
    parameter logic [31:0] CPU_ID      = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_num,
    input  logic        csr_re,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    output logic        timer_int,
    output logic [31:0] cnt_id,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi
);

    localparam logic [TIMER_WIDTH-1:0] TVAL_ONE = TIMER_WIDTH'(1);

    logic [31:0]            tid_q,  tid_d;
    logic [TIMER_WIDTH-1:0] tcfg_q, tcfg_d;
    logic [TIMER_WIDTH-1:0] tval_q, tval_d;
    logic                   timer_en_q,  timer_en_d;
    logic                   timer_int_q, timer_int_d;

    logic we_tid;
    logic we_tcfg;
    logic we_ticlr;
    logic expire;
    logic [TIMER_WIDTH-1:0] reload_val;

    assign we_tid   = csr_we && (csr_num == CSR_TID);
    assign we_tcfg  = csr_we && (csr_num == CSR_TCFG);
    assign we_ticlr = csr_we && (csr_num == CSR_TICLR);

    assign reload_val = {tcfg_q[TIMER_WIDTH-1:TCFG_INITVAL], 2'b00};

    always_comb begin
        tid_d       = tid_q;
        tcfg_d      = tcfg_q;
        tval_d      = tval_q;
        timer_en_d  = timer_en_q;
        timer_int_d = timer_int_q;
        expire      = 1'b0;

        if (we_tid) begin
            tid_d = csr_wdata;
        end

        // A TCFG write always reloads TVAL, even with En=0, and suppresses countdown.
        if (we_tcfg) begin
            tcfg_d     = csr_wdata[TIMER_WIDTH-1:0];
            tval_d     = {csr_wdata[TIMER_WIDTH-1:TCFG_INITVAL], 2'b00};
            timer_en_d = csr_wdata[TCFG_EN];
        end else if (timer_en_q) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TVAL_ONE;
            end else begin
                expire = 1'b1;
                if (tcfg_q[TCFG_PERIODIC]) begin
                    tval_d = reload_val;
                end else begin
                    tval_d     = '1;
                    timer_en_d = 1'b0;
                end
            end
        end

        // Hardware expiry wins over a software clear in the same cycle.
        if (expire) begin
            timer_int_d = 1'b1;
        end else if (we_ticlr && csr_wdata[TICLR_CLR]) begin
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tid_q       <= CPU_ID;
            tcfg_q      <= '0;
            tval_q      <= '1;
            timer_en_q  <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            tid_q       <= tid_d;
            tcfg_q      <= tcfg_d;
            tval_q      <= tval_d;
            timer_en_q  <= timer_en_d;
            timer_int_q <= timer_int_d;
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_re) begin
            case (csr_num)
                CSR_TID:  csr_rdata = tid_q;
                CSR_TCFG: csr_rdata = CSR_DATA_W'(tcfg_q);
                CSR_TVAL: csr_rdata = CSR_DATA_W'(tval_q);
                default:  csr_rdata = '0;
            endcase
        end
    end

    assign timer_int = timer_int_q;
    assign cnt_id    = tid_q;

`ifdef CSR_TIMER_STABLE_COUNTER_EN
    csr_timer_stable_counter u_stable_counter (
        .clk   (clk),
        .reset (reset),
        .lo_o  (cnt_lo),
        .hi_o  (cnt_hi)
    );
`else
    assign cnt_lo = '0;
    assign cnt_hi = '0;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: a vector table for CSR access and one-shot countdown,
// then hand-written sequences for periodic wrap, TICLR races, En=0 freeze and mid-count reset.
module tb_csr_timer;

    localparam logic [13:0] A_TID   = 14'h040;
    localparam logic [13:0] A_TCFG  = 14'h041;
    localparam logic [13:0] A_TVAL  = 14'h042;
    localparam logic [13:0] A_TICLR = 14'h044;
    localparam logic [13:0] A_OTHER = 14'h043;
    localparam logic [31:0] MY_CPU  = 32'h0000_0005;
    localparam logic [31:0] ONES    = 32'hFFFF_FFFF;

    logic        clk;
    logic        reset;
    logic [13:0] csr_num;
    logic        csr_re;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic        timer_int;
    logic [31:0] cnt_id;
    logic [31:0] cnt_lo;
    logic [31:0] cnt_hi;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] cnt_m;

    typedef struct {
        logic [13:0] num;
        logic        re;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_int;
    } vec_t;

    vec_t tbl[$];

    csr_timer #(
        .TIMER_WIDTH (32),
        .CPU_ID      (MY_CPU)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .csr_num   (csr_num),
        .csr_re    (csr_re),
        .csr_rdata (csr_rdata),
        .csr_we    (csr_we),
        .csr_wdata (csr_wdata),
        .timer_int (timer_int),
        .cnt_id    (cnt_id),
        .cnt_lo    (cnt_lo),
        .cnt_hi    (cnt_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stable counter: zero at reset, +1 per edge afterwards.
    always @(posedge clk) begin
        if (reset) cnt_m <= 64'd0;
        else       cnt_m <= cnt_m + 64'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic add(input logic [13:0] num, input logic re, input logic we,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_int);
        vec_t v;
        v.num = num; v.re = re; v.we = we; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_int = exp_int;
        tbl.push_back(v);
    endtask

    // Drive one cycle, check outputs before the edge, then advance past the edge.
    task automatic cyc(input string name, input logic [13:0] num, input logic re, input logic we,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_int);
        logic [31:0] exp_lo, exp_hi;
        csr_num = num; csr_re = re; csr_we = we; csr_wdata = wdata;
        @(negedge clk);
`ifdef CSR_TIMER_STABLE_COUNTER_EN
        exp_lo = cnt_m[31:0];
        exp_hi = cnt_m[63:32];
`else
        exp_lo = 32'd0;
        exp_hi = 32'd0;
`endif
        chk({name, " rdata"}, csr_rdata, exp_rd);
        chk({name, " timer_int"}, {31'd0, timer_int}, {31'd0, exp_int});
        chk({name, " cnt_lo"}, cnt_lo, exp_lo);
        chk({name, " cnt_hi"}, cnt_hi, exp_hi);
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        csr_re = 1'b0;
    endtask

    initial begin
        reset = 1'b1; csr_num = '0; csr_re = 1'b0; csr_we = 1'b0; csr_wdata = '0;

        add(A_TID,   1, 0, 0, MY_CPU, 0);
        add(A_TCFG,  1, 0, 0, 0, 0);
        add(A_TVAL,  1, 0, 0, ONES, 0);
        add(A_TICLR, 1, 0, 0, 0, 0);
        add(A_OTHER, 1, 0, 0, 0, 0);
        add(A_TID,   0, 0, 0, 0, 0);
        add(A_TID,   0, 1, 32'h0000_ABCD, 0, 0);
        add(A_TID,   1, 0, 0, 32'h0000_ABCD, 0);
        add(A_OTHER, 0, 1, 32'h11, 0, 0);
        add(A_TCFG,  1, 0, 0, 0, 0);
        add(A_TVAL,  0, 1, 32'h5, 0, 0);
        add(A_TVAL,  1, 0, 0, ONES, 0);
        add(A_TCFG,  0, 1, 32'h11, 0, 0);
        for (int i = 0; i <= 16; i++) add(A_TVAL, 1, 0, 0, 32'(16 - i), 0);
        add(A_TVAL,  1, 0, 0, ONES, 1);
        add(A_TVAL,  1, 0, 0, ONES, 1);
        add(A_TCFG,  1, 0, 0, 32'h11, 1);
        add(A_TICLR, 0, 1, 32'h1, 0, 1);
        add(A_TICLR, 1, 0, 0, 0, 0);
        add(A_TVAL,  1, 0, 0, ONES, 0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("cnt_id reset", cnt_id, MY_CPU);
        for (int i = 0; i < tbl.size(); i++)
            cyc($sformatf("tbl[%0d]", i), tbl[i].num, tbl[i].re, tbl[i].we,
                tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_int);
        chk("cnt_id written", cnt_id, 32'h0000_ABCD);

        // Periodic, InitVal=2: reload 8, fire on each wrap.
        cyc("per wr", A_TCFG, 0, 1, 32'h0B, 0, 0);
        for (int k = 0; k <= 8; k++) cyc($sformatf("per a%0d", k), A_TVAL, 1, 0, 0, 32'(8 - k), 0);
        cyc("per wrap1", A_TVAL, 1, 0, 0, 32'd8, 1);
        cyc("per 7", A_TVAL, 1, 0, 0, 32'd7, 1);
        cyc("per clr", A_TICLR, 0, 1, 32'h1, 0, 1);
        for (int k = 0; k <= 5; k++) cyc($sformatf("per b%0d", k), A_TVAL, 1, 0, 0, 32'(5 - k), 0);
        cyc("per wrap2", A_TVAL, 1, 0, 0, 32'd8, 1);
        cyc("per clr2", A_TICLR, 0, 1, 32'h1, 0, 1);
        for (int k = 0; k <= 5; k++) cyc($sformatf("per c%0d", k), A_TVAL, 1, 0, 0, 32'(6 - k), 0);
        // TICLR in the expiry cycle: set must win.
        cyc("race clr", A_TICLR, 0, 1, 32'h1, 0, 0);
        cyc("race int", A_TVAL, 1, 0, 0, 32'd8, 1);

        // En=0 during countdown: reload, freeze, timer_int untouched.
        cyc("stop wr", A_TCFG, 0, 1, 32'h0A, 0, 1);
        for (int k = 0; k < 3; k++) cyc($sformatf("stop %0d", k), A_TVAL, 1, 0, 0, 32'd8, 1);
        cyc("stop tcfg", A_TCFG, 1, 0, 0, 32'h0A, 1);

        // InitVal=0 periodic: fires every cycle, TICLR cannot hold it low.
        cyc("z clr", A_TICLR, 0, 1, 32'h1, 0, 1);
        cyc("z wr", A_TCFG, 0, 1, 32'h03, 0, 0);
        cyc("z 0", A_TVAL, 1, 0, 0, 32'd0, 0);
        cyc("z 1", A_TVAL, 1, 0, 0, 32'd0, 1);
        cyc("z clr2", A_TICLR, 0, 1, 32'h1, 0, 1);
        cyc("z 2", A_TVAL, 1, 0, 0, 32'd0, 1);

        // Reset mid-countdown.
        cyc("rst wr", A_TCFG, 0, 1, 32'h11, 0, 1);
        cyc("rst a", A_TVAL, 1, 0, 0, 32'h10, 1);
        cyc("rst b", A_TVAL, 1, 0, 0, 32'h0F, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc("rst tid", A_TID, 1, 0, 0, MY_CPU, 0);
        cyc("rst tcfg", A_TCFG, 1, 0, 0, 0, 0);
        cyc("rst tval", A_TVAL, 1, 0, 0, ONES, 0);
        cyc("rst hold", A_TVAL, 1, 0, 0, ONES, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
